// File: rtl/vga_timing.sv
// vga_timing: free-running raster timing generator (default 1280x1024 @ 60 Hz).
// Two counters walk the raster; every output is a registered decode of the
// counter values, so x/y/disp_en/syncs all describe the same pixel.
module vga_timing #(
    parameter int   H_VISIBLE = 1280,
    parameter int   H_FRONT   = 48,
    parameter int   H_SYNC    = 112,
    parameter int   H_BACK    = 248,
    parameter int   V_VISIBLE = 1024,
    parameter int   V_FRONT   = 1,
    parameter int   V_SYNC    = 3,
    parameter int   V_BACK    = 38,
    parameter logic H_POL     = 1'b1,
    parameter logic V_POL     = 1'b1
) (
    input  logic        VGA_CLK,
    input  logic        reset,
    output logic        h_sync,
    output logic        v_sync,
    output logic        disp_en,
    output logic [10:0] x,
    output logic [10:0] y,
    output logic        line_start,
    output logic        frame_start
);

    localparam int H_TOTAL = H_VISIBLE + H_FRONT + H_SYNC + H_BACK;
    localparam int V_TOTAL = V_VISIBLE + V_FRONT + V_SYNC + V_BACK;

    // Counters are 11 bits wide, so neither total may exceed 2048.
    generate
        if (H_TOTAL > 2048) begin : g_h_total_check
            $error("vga_timing: H_TOTAL %0d exceeds 2048", H_TOTAL);
        end
        if (V_TOTAL > 2048) begin : g_v_total_check
            $error("vga_timing: V_TOTAL %0d exceeds 2048", V_TOTAL);
        end
    endgenerate

    localparam logic [10:0] H_LAST   = 11'(H_TOTAL - 1);
    localparam logic [10:0] V_LAST   = 11'(V_TOTAL - 1);
    // Region bounds are 12 bits so an end value of 2048 is representable.
    localparam logic [11:0] H_DE_END = 12'(H_VISIBLE);
    localparam logic [11:0] H_SY_BEG = 12'(H_VISIBLE + H_FRONT);
    localparam logic [11:0] H_SY_END = 12'(H_VISIBLE + H_FRONT + H_SYNC);
    localparam logic [11:0] V_DE_END = 12'(V_VISIBLE);
    localparam logic [11:0] V_SY_BEG = 12'(V_VISIBLE + V_FRONT);
    localparam logic [11:0] V_SY_END = 12'(V_VISIBLE + V_FRONT + V_SYNC);

    logic [10:0] h_cnt_q, h_cnt_d;
    logic [10:0] v_cnt_q, v_cnt_d;
    logic        h_wrap, v_wrap;
    logic [11:0] h_ext, v_ext;

    logic [10:0] x_q, y_q;
    logic        disp_en_q, h_sync_q, v_sync_q, line_start_q, frame_start_q;
    logic        disp_en_d, h_sync_d, v_sync_d, line_start_d, frame_start_d;

    // Next counter values: h wraps at end of line, v advances on the h wrap.
    always_comb begin
        h_wrap  = (h_cnt_q == H_LAST);
        v_wrap  = (v_cnt_q == V_LAST);
        h_cnt_d = h_wrap ? '0 : h_cnt_q + 11'd1;
        v_cnt_d = v_cnt_q;
        if (h_wrap) begin
            v_cnt_d = v_wrap ? '0 : v_cnt_q + 11'd1;
        end
    end

    // Output decode of the current counter position.
    always_comb begin
        h_ext         = {1'b0, h_cnt_q};
        v_ext         = {1'b0, v_cnt_q};
        disp_en_d     = (h_ext < H_DE_END) && (v_ext < V_DE_END);
        h_sync_d      = ((h_ext >= H_SY_BEG) && (h_ext < H_SY_END)) ? H_POL : ~H_POL;
        v_sync_d      = ((v_ext >= V_SY_BEG) && (v_ext < V_SY_END)) ? V_POL : ~V_POL;
        line_start_d  = (h_cnt_q == '0);
        frame_start_d = (h_cnt_q == '0) && (v_cnt_q == '0);
    end

    // Raster position counters.
    always_ff @(posedge VGA_CLK or posedge reset) begin
        if (reset) begin
            h_cnt_q <= '0;
            v_cnt_q <= '0;
        end else begin
            h_cnt_q <= h_cnt_d;
            v_cnt_q <= v_cnt_d;
        end
    end

    // Registered outputs, one clock behind the counters and mutually aligned.
    always_ff @(posedge VGA_CLK or posedge reset) begin
        if (reset) begin
            x_q           <= '0;
            y_q           <= '0;
            disp_en_q     <= 1'b0;
            h_sync_q      <= ~H_POL;
            v_sync_q      <= ~V_POL;
            line_start_q  <= 1'b0;
            frame_start_q <= 1'b0;
        end else begin
            x_q           <= h_cnt_q;
            y_q           <= v_cnt_q;
            disp_en_q     <= disp_en_d;
            h_sync_q      <= h_sync_d;
            v_sync_q      <= v_sync_d;
            line_start_q  <= line_start_d;
            frame_start_q <= frame_start_d;
        end
    end

    assign x           = x_q;
    assign y           = y_q;
    assign disp_en     = disp_en_q;
    assign h_sync      = h_sync_q;
    assign v_sync      = v_sync_q;
    assign line_start  = line_start_q;
    assign frame_start = frame_start_q;

endmodule

// File: doc/vga_timing.md
# vga_timing

Free-running raster timing generator for the 1280x1024 @ 60 Hz VGA output. It produces the horizontal and vertical sync pulses, the active-video flag `disp_en`, and the current pixel coordinates `x`/`y`. These outputs feed the pixel/colour generators, which register `r`/`g`/`b` on the same `VGA_CLK`. The block is the source end of the `x`/`y`/`disp_en` interface those generators consume.

## Interface

Parameters:
- `H_VISIBLE`, default 1280: active pixels per line.
- `H_FRONT`, default 48: horizontal front porch, in clocks.
- `H_SYNC`, default 112: horizontal sync width, in clocks.
- `H_BACK`, default 248: horizontal back porch, in clocks. Line total is 1688.
- `V_VISIBLE`, default 1024: active lines per frame.
- `V_FRONT`, default 1: vertical front porch, in lines.
- `V_SYNC`, default 3: vertical sync width, in lines.
- `V_BACK`, default 38: vertical back porch, in lines. Frame total is 1066.
- `H_POL`, default 1: active level of `h_sync` (1 = positive pulse).
- `V_POL`, default 1: active level of `v_sync`.

Ports:
- `VGA_CLK`, input, 1: pixel clock, 108 MHz nominal. All logic runs on the rising edge.
- `reset`, input, 1: asynchronous, active-high reset.
- `h_sync`, output, 1: horizontal sync to the DAC/connector.
- `v_sync`, output, 1: vertical sync to the DAC/connector.
- `disp_en`, output, 1: high while the current pixel is in the visible area.
- `x`, output, 11: horizontal position, 0..H_TOTAL-1.
- `y`, output, 11: vertical position, 0..V_TOTAL-1.
- `line_start`, output, 1: one-clock pulse on the first pixel of every line.
- `frame_start`, output, 1: one-clock pulse on pixel (0,0) of every frame.

## Operation

Totals and counters:
- H_TOTAL = H_VISIBLE+H_FRONT+H_SYNC+H_BACK.
- V_TOTAL = V_VISIBLE+V_FRONT+V_SYNC+V_BACK.
- Both totals must be ≤ 2048. A value above 2048 is an elaboration error, enforced by a generate-time check.
- Internal counters: `h_cnt` counts 0..H_TOTAL-1, and `v_cnt` counts 0..V_TOTAL-1.
- `h_cnt` increments every clock. At H_TOTAL-1 it wraps to 0, and `v_cnt` advances on that same edge.
- `v_cnt` wraps from V_TOTAL-1 to 0 on the edge where `h_cnt` wraps. The simultaneous wrap of both counters is the frame boundary. No other event exists.

Output decode:
- Every output is a registered function of the counter values in the same cycle.
- `x` = `h_cnt` and `y` = `v_cnt`. The values are raw and are not clamped during blanking. Consumers must qualify them with `disp_en`.
- `disp_en` = (`h_cnt` < H_VISIBLE) && (`v_cnt` < V_VISIBLE).
- `h_sync` = H_POL when H_VISIBLE+H_FRONT ≤ `h_cnt` < H_VISIBLE+H_FRONT+H_SYNC. Otherwise it is ~H_POL.
- `v_sync` = V_POL when V_VISIBLE+V_FRONT ≤ `v_cnt` < V_VISIBLE+V_FRONT+V_SYNC. Otherwise it is ~V_POL. It changes only at line boundaries.
- `line_start` = (`h_cnt` == 0).
- `frame_start` = (`h_cnt` == 0 && `v_cnt` == 0).

Reset behaviour:
- While `reset` is high: `h_cnt` = `v_cnt` = 0, `x` = 0, `y` = 0, `disp_en` = 0, `line_start` = 0, `frame_start` = 0, `h_sync` = ~H_POL, `v_sync` = ~V_POL.
- Assertion of `reset` mid-frame takes effect immediately and asynchronously. There is no partial-frame recovery.

## Timing

- The counters see their first increment-free edge after `reset` deasserts. On that edge the counters are at (0,0), and the registered outputs capture x=0, y=0, `disp_en`=1, `line_start`=1, `frame_start`=1.
- Output latency is 1 clock behind the counters. All outputs are mutually aligned: `x`, `y`, `disp_en` and the syncs describe the same pixel in the same cycle.
- A downstream colour register adds 1 more clock. Sync-to-colour skew compensation is the integrator's responsibility and is outside this block.
- `disp_en` is high for exactly H_VISIBLE consecutive clocks per visible line. It is low for the whole of every line with `y` ≥ V_VISIBLE.
- Line period is H_TOTAL clocks (1688). Frame period is H_TOTAL*V_TOTAL clocks (1,799,408).
- `h_sync` is active for exactly H_SYNC clocks per line, including during vertical blanking.
- `v_sync` is active for exactly V_SYNC*H_TOTAL clocks per frame. Its edges coincide with `line_start`.

## Test plan

- Reset release: hold `reset` 5 clocks, then release.
  - During reset: `h_sync`=0, `v_sync`=0, `disp_en`=0, x=y=0.
  - First output edge after release: `frame_start`=1 with x=0, y=0, `disp_en`=1.
- Line timing:
  - `disp_en` falls when x changes from 1279 to 1280.
  - `h_sync` rises at x=1328 and falls at x=1440.
  - x wraps from 1687 to 0 and y increments by 1 on that wrap.
- Frame timing:
  - `disp_en` is 0 for the whole of lines 1024..1065.
  - `v_sync` is high for lines 1025..1027, which is 5064 clocks.
  - `frame_start` pulses are 1,799,408 clocks apart.
- Polarity: build with H_POL=0, V_POL=0.
  - Sync pulses invert.
  - Reset values become `h_sync`=1 and `v_sync`=1.
  - Positions and widths are unchanged.
- Mid-frame reset: assert `reset` at x=700, y=500.
  - Outputs go to their reset values within the same cycle, asynchronously.
  - After release, timing restarts at (0,0) with `frame_start`=1.
- Small-parameter build: H_VISIBLE=4, H_FRONT=1, H_SYNC=2, H_BACK=1, V_VISIBLE=3, V_FRONT=1, V_SYNC=1, V_BACK=1.
  - The full 8x6 raster is checked pixel-by-pixel against a reference model over 3 frames.
